// File: rtl/mesi_bus_arbiter.sv
// Round-robin snoop-bus and memory-port sequencer for the 4-core MESI cache.
// Flow: grant one core, snoop, collect any flush, run one memory transaction, respond.
module mesi_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128,
  parameter int MEM_TMO   = 255,
  localparam int CW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int TW       = $clog2(MEM_TMO + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        req_wr,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*LINE_W-1:0] wb_data,
  input  logic [NUM_CORES-1:0]        c_flush,
  input  logic [LINE_W-1:0]           flush_data,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        stall,
  output logic                        snoop_valid,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic [CW-1:0]               snoop_src,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_read_data,
  input  logic                        mem_ready,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [LINE_W-1:0]           rsp_data,
  output logic                        timeout_err,
  output logic [2:0]                  dbg_state
);

  // Handshake: req is held by a core until the cycle its rsp_valid bit is high;
  // mem_req is held with stable address/data until the single-cycle mem_ready.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SNOOP = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_rr, r_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [LINE_W-1:0]   r_wdata, r_line;
  logic [TW-1:0]       r_tmo;
  logic                r_tmo_err;

  logic [CW-1:0]        w_pick_idx;
  logic                 w_pick_any;
  logic [NUM_CORES-1:0] w_flush_vec;
  logic                 w_flush_any;
  logic                 w_tmo_hit;
  logic                 w_busy;
  int                   w_c;

  // First requesting core at or above the round-robin pointer, wrapping around.
  always_comb begin
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    w_c        = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_c = (int'(r_rr) + k) % NUM_CORES;
      if (!w_pick_any && req[w_c]) begin
        w_pick_any = 1'b1;
        w_pick_idx = CW'(w_c);
      end
    end
  end

  assign w_busy      = (r_state == S_GRANT) || (r_state == S_SNOOP) ||
                       (r_state == S_MEM)   || (r_state == S_WB);
  assign gnt         = w_busy ? (NUM_CORES'(1) << r_idx) : '0;
  assign w_flush_vec = c_flush & ~gnt;
  assign w_flush_any = |w_flush_vec;
  assign w_tmo_hit   = (r_tmo == TW'(MEM_TMO - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_any) w_next = S_GRANT;
      S_GRANT: w_next = r_wr ? S_MEM : S_SNOOP;
      S_SNOOP: w_next = w_flush_any ? S_WB : S_MEM;
      S_MEM,
      S_WB:    if (mem_ready || w_tmo_hit) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_line    <= '0;
      r_tmo     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_pick_any) begin
          r_idx   <= w_pick_idx;
          r_addr  <= req_addr[w_pick_idx*ADDR_W +: ADDR_W];
          r_wr    <= req_wr[w_pick_idx];
          r_wdata <= wb_data[w_pick_idx*LINE_W +: LINE_W];
          r_line  <= '0;
          r_tmo   <= '0;
        end
        S_SNOOP: if (w_flush_any) begin
          r_wdata <= flush_data;
          r_line  <= flush_data;
        end
        S_MEM, S_WB: begin
          if (mem_ready) begin
            if (r_state == S_MEM && !r_wr) r_line <= mem_read_data;
          end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
            r_line    <= '0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RESP: begin
          r_rr  <= (int'(r_idx) == NUM_CORES - 1) ? '0 : r_idx + CW'(1);
          r_tmo <= '0;
        end
        default: ;
      endcase
    end
  end

  assign snoop_valid = (r_state == S_GRANT) && !r_wr;
  assign snoop_addr  = snoop_valid ? r_addr : '0;
  assign snoop_src   = snoop_valid ? r_idx : '0;
  assign mem_req     = (r_state == S_MEM) || (r_state == S_WB);
  assign mem_we      = ((r_state == S_MEM) && r_wr) || (r_state == S_WB);
  assign mem_addr    = mem_req ? r_addr : '0;
  assign mem_wdata   = mem_we ? r_wdata : '0;
  assign rsp_valid   = (r_state == S_RESP) ? (NUM_CORES'(1) << r_idx) : '0;
  assign rsp_data    = (r_state == S_RESP) ? r_line : '0;
  assign timeout_err = r_tmo_err;
  // Gated by reset so every output reads zero while reset is held.
  assign stall       = req & ~rsp_valid & {NUM_CORES{rst}};
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter: fills, round robin, snoop flushes,
// memory timeout and asynchronous reset in the middle of a transaction.
module tb_mesi_bus_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req, req_wr, c_flush;
  logic [127:0] req_addr;
  logic [511:0] wb_data;
  logic [127:0] flush_data, mem_read_data;
  logic         mem_ready;
  logic [3:0]   gnt, stall, rsp_valid;
  logic         snoop_valid, mem_req, mem_we, timeout_err;
  logic [31:0]  snoop_addr, mem_addr;
  logic [1:0]   snoop_src;
  logic [127:0] mem_wdata, rsp_data;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] BEEF = 128'hBEEF;

  mesi_bus_arbiter #(.NUM_CORES(4), .ADDR_W(32), .LINE_W(128), .MEM_TMO(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .wb_data(wb_data), .c_flush(c_flush), .flush_data(flush_data),
    .gnt(gnt), .stall(stall), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .snoop_src(snoop_src), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change on the falling edge, outputs sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int core, input logic wr, input logic [31:0] addr,
                         input logic [127:0] line);
    req[core]                = 1'b1;
    req_wr[core]             = wr;
    req_addr[core*32 +: 32]  = addr;
    wb_data[core*128 +: 128] = line;
  endtask

  // Scoreboard: expected line for the next completion
  task automatic chk_rsp(input string tag, input logic [3:0] exp_vld);
    logic [127:0] e;
    chk({tag, "_vld"}, 128'(rsp_valid), 128'(exp_vld));
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_q observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, rsp_data, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b0; req = '0; req_wr = '0; c_flush = '0; req_addr = '0; wb_data = '0;
    flush_data = '0; mem_read_data = '0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_gnt", 128'(gnt), 0);
    chk("rst_state", 128'(dbg_state), 0);
    chk("rst_tmo", 128'(timeout_err), 0);
    rst = 1'b1;
    tick();

    // 1: single fill, memory answers in the third MEM cycle
    set_req(0, 1'b0, 32'h100, '0);
    exp_q.push_back(A5);
    tick();
    chk("t1_gnt", 128'(gnt), 128'h1);
    chk("t1_snp_vld", 128'(snoop_valid), 1);
    chk("t1_snp_addr", 128'(snoop_addr), 128'h100);
    chk("t1_stall", 128'(stall), 128'h1);
    tick();
    chk("t1_snp_one_cycle", 128'(snoop_valid), 0);
    tick();
    chk("t1_mem_req", 128'(mem_req), 1);
    chk("t1_mem_rd", 128'(mem_we), 0);
    chk("t1_mem_addr", 128'(mem_addr), 128'h100);
    tick();
    tick();
    mem_ready = 1'b1; mem_read_data = A5;
    tick();
    mem_ready = 1'b0; mem_read_data = '0;
    chk_rsp("t1_rsp", 4'b0001);
    chk("t1_stall_clear", 128'(stall), 0);
    req = '0;
    tick();
    chk("t1_gnt_drop", 128'(gnt), 0);

    // 2: round robin with all cores requesting and memory always ready
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, 32'h1000 + 32'(c) * 32'h40, '0);
    mem_ready = 1'b1; mem_read_data = 128'h5A;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (gnt == 4'b0 && n < 20) begin tick(); n++; end
      chk("t2_gnt", 128'(gnt), 128'(4'b0001 << (t % 4)));
      // gnt visible one cycle after the decision; rsp lands four cycles after decision
      n = 0;
      while (rsp_valid == 4'b0 && n < 20) begin tick(); n++; end
      chk("t2_latency", 128'(n), 3);
      chk("t2_rsp", 128'(rsp_valid), 128'(4'b0001 << (t % 4)));
      if (t == 4) req = '0;
      tick();
    end
    mem_ready = 1'b0; mem_read_data = '0;

    // 3: core2 fill, core1 flushes its modified copy
    set_req(2, 1'b0, 32'h200, '0);
    exp_q.push_back(BEEF);
    tick();
    chk("t3_gnt", 128'(gnt), 128'h4);
    chk("t3_snp_src", 128'(snoop_src), 2);
    chk("t3_snp_addr", 128'(snoop_addr), 128'h200);
    c_flush = 4'b0010; flush_data = BEEF;
    tick();
    tick();
    c_flush = '0; flush_data = '0;
    chk("t3_wb_state", 128'(dbg_state), 4);
    chk("t3_mem_we", 128'(mem_we), 1);
    chk("t3_mem_addr", 128'(mem_addr), 128'h200);
    chk("t3_mem_wdata", mem_wdata, BEEF);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_rsp("t3_rsp", 4'b0100);
    req = '0;
    tick();

    // 4: core1 requests; flushes from 1,2,3 -- own flush masked, flush path taken
    set_req(1, 1'b0, 32'h300, '0);
    exp_q.push_back(128'h1234_CAFE);
    tick();
    chk("t4_gnt", 128'(gnt), 128'h2);
    c_flush = 4'b1110; flush_data = 128'h1234_CAFE;
    tick();
    tick();
    c_flush = '0; flush_data = '0;
    chk("t4_wb_we", 128'(mem_we), 1);
    chk("t4_wb_data", mem_wdata, 128'h1234_CAFE);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_rsp("t4_rsp", 4'b0010);
    req = '0;
    tick();
    // 4b: only the requester's own flush -> ignored, memory read
    set_req(1, 1'b0, 32'h340, '0);
    exp_q.push_back(128'h77);
    tick();
    c_flush = 4'b0010; flush_data = 128'hBAD;
    tick();
    tick();
    c_flush = '0; flush_data = '0;
    chk("t4b_state", 128'(dbg_state), 3);
    chk("t4b_mem_rd", 128'(mem_we), 0);
    mem_ready = 1'b1; mem_read_data = 128'h77;
    tick();
    mem_ready = 1'b0; mem_read_data = '0;
    chk_rsp("t4b_rsp", 4'b0010);
    req = '0;
    tick();

    // 5: memory never answers -> timeout after 8 MEM cycles
    set_req(3, 1'b0, 32'h400, '0);
    exp_q.push_back('0);
    tick(); tick(); tick();
    chk("t5_mem_first", 128'(mem_req), 1);
    for (int i = 0; i < 7; i++) tick();
    chk("t5_mem_last", 128'(mem_req), 1);
    chk("t5_no_tmo_yet", 128'(timeout_err), 0);
    tick();
    chk("t5_tmo", 128'(timeout_err), 1);
    chk_rsp("t5_rsp", 4'b1000);
    req = '0;
    tick();
    // next request (core0 write-back) is still served
    set_req(0, 1'b1, 32'h500, 128'hDEAD);
    exp_q.push_back('0);
    tick();
    chk("t5_wb_gnt", 128'(gnt), 128'h1);
    chk("t5_wb_nosnoop", 128'(snoop_valid), 0);
    tick();
    chk("t5_wb_we", 128'(mem_we), 1);
    chk("t5_wb_addr", 128'(mem_addr), 128'h500);
    chk("t5_wb_wdata", mem_wdata, 128'hDEAD);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_rsp("t5_wb_rsp", 4'b0001);
    chk("t5_tmo_sticky", 128'(timeout_err), 1);
    req = '0; req_wr = '0;
    tick();

    // 6: asynchronous reset while in MEM
    set_req(1, 1'b0, 32'h600, '0);
    tick(); tick(); tick();
    chk("t6_in_mem", 128'(mem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_gnt", 128'(gnt), 0);
    chk("t6_rst_mem_req", 128'(mem_req), 0);
    chk("t6_rst_stall", 128'(stall), 0);
    chk("t6_rst_tmo", 128'(timeout_err), 0);
    chk("t6_rst_rsp", 128'(rsp_valid), 0);
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    set_req(2, 1'b0, 32'h700, '0);
    tick();
    chk("t6_gnt_after", 128'(gnt), 128'h4);
    req = '0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
